// File: rtl/uart_led_cmd_rx.sv
// -----------------------------------------------------------------------------
// uart_led_cmd_rx
//
// Remote-control receive path for the LED board. A UART 8N1 receiver feeds a
// small command decoder that drives the eight LEDs from bytes sent by a host.
//
// Commands (first byte of a command):
//   'L' (0x4C) : the next byte is loaded into leds
//   'T' (0x54) : the next byte is an XOR mask applied to leds
//   'R' (0x52) : rotate leds left by one, bit 7 wraps to bit 0
//   'C' (0x43) : clear leds
//   anything else is ignored without a pulse
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   rx         in   asynchronous serial line, idles high
//   leds       out  [7:0] registered LED drive (0x01 out of reset)
//   cmd_valid  out  one-cycle pulse when a command has been executed
//   frame_err  out  one-cycle pulse when a stop bit is sampled low
// -----------------------------------------------------------------------------
module uart_led_cmd_rx #(
    parameter int CLK_FREQ       = 25_000_000,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] leds,
    output logic       cmd_valid,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W         = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    // Bit-level receiver states
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    // Command decoder states
    localparam logic CMD_WAIT = 1'b0;
    localparam logic ARG_WAIT = 1'b1;

    localparam logic [7:0] OP_LOAD   = 8'h4C;
    localparam logic [7:0] OP_TOGGLE = 8'h54;
    localparam logic [7:0] OP_ROTATE = 8'h52;
    localparam logic [7:0] OP_CLEAR  = 8'h43;

    logic             rx_p0;
    logic             rx_p1;
    logic             rx_p2;
    logic [2:0]       bit_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             byte_vld;
    logic             cmd_state;
    logic             is_toggle;
    logic [TO_W-1:0]  to_cnt;

    // -------------------------------------------------------------------------
    // Synchronizer: rx_p1 is the only copy of rx used by the logic; rx_p2 is
    // its one-cycle-old value for falling-edge detection.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    // -------------------------------------------------------------------------
    // Bit FSM: byte_vld / frame_err are registered on the stop-bit sample edge
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_state <= S_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            rx_byte   <= 8'h00;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (bit_state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    if (rx_p2 && !rx_p1) begin
                        bit_state <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        // A line that is high again at mid start bit was a glitch
                        bit_state <= rx_p1 ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        rx_byte <= {rx_p1, rx_byte[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_p1) begin
                            byte_vld  <= 1'b1;
                            bit_state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            bit_state <= S_WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    clk_cnt <= '0;
                    if (rx_p1) begin
                        bit_state <= S_IDLE;
                    end
                end
                default: begin
                    clk_cnt   <= '0;
                    bit_state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Command FSM: acts one cycle after byte_vld / frame_err
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_state <= CMD_WAIT;
            is_toggle <= 1'b0;
            to_cnt    <= '0;
            leds      <= 8'h01;
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            case (cmd_state)
                CMD_WAIT: begin
                    to_cnt <= '0;
                    if (byte_vld) begin
                        case (rx_byte)
                            OP_LOAD: begin
                                is_toggle <= 1'b0;
                                cmd_state <= ARG_WAIT;
                            end
                            OP_TOGGLE: begin
                                is_toggle <= 1'b1;
                                cmd_state <= ARG_WAIT;
                            end
                            OP_ROTATE: begin
                                leds      <= {leds[6:0], leds[7]};
                                cmd_valid <= 1'b1;
                            end
                            OP_CLEAR: begin
                                leds      <= 8'h00;
                                cmd_valid <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ARG_WAIT: begin
                    if (frame_err) begin
                        cmd_state <= CMD_WAIT;
                    end else if (byte_vld) begin
                        // Any value is data here, opcodes included
                        leds      <= is_toggle ? (leds ^ rx_byte) : rx_byte;
                        cmd_valid <= 1'b1;
                        cmd_state <= CMD_WAIT;
                    end else if (to_cnt == TO_LAST) begin
                        cmd_state <= CMD_WAIT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    cmd_state <= CMD_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_led_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_led_cmd_rx
//
// Bench for uart_led_cmd_rx at CLK_FREQ=1 MHz, BAUD=100 kbaud (10 clocks per
// bit). Stimulus tasks push the expected cmd_valid / frame_err events (with
// the resulting LED value) into a queue; a negedge monitor pops them as the
// DUT pulses and also checks that leds never move without a pulse.
// -----------------------------------------------------------------------------
module tb_uart_led_cmd_rx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int TIMEOUT  = 200;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] leds;
    logic       cmd_valid;
    logic       frame_err;

    typedef struct {
        bit         is_ferr;
        logic [7:0] leds;
        int         cyc0;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    logic [7:0] cur_leds    = 8'h01;
    bit         prev_cv     = 1'b0;
    bit         prev_fe     = 1'b0;

    uart_led_cmd_rx #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD          (BAUD),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .leds     (leds),
        .cmd_valid(cmd_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cur_leds = 8'h01;
            vectors++;
            if (leds !== 8'h01 || cmd_valid !== 1'b0 || frame_err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_values: leds=%h cmd_valid=%b frame_err=%b, required leds=01 cmd_valid=0 frame_err=0",
                         leds, cmd_valid, frame_err);
            end
        end else begin
            vectors++;
            if (cmd_valid === 1'b1 && frame_err === 1'b1) begin
                miscompares++;
                $display("FAIL pulse_overlap: cmd_valid=1 frame_err=1 at cycle %0d, required never both", cyc);
            end
            vectors++;
            if ((cmd_valid === 1'b1 && prev_cv) || (frame_err === 1'b1 && prev_fe)) begin
                miscompares++;
                $display("FAIL pulse_width: pulse high 2 cycles at cycle %0d, required 1 cycle", cyc);
            end
            if (cmd_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0 || exp_q[0].is_ferr) begin
                    miscompares++;
                    $display("FAIL unexpected_cmd_valid: cmd_valid=1 leds=%h at cycle %0d, required no pulse", leds, cyc);
                    cur_leds = leds;
                end else begin
                    e = exp_q.pop_front();
                    vectors++;
                    if (leds !== e.leds) begin
                        miscompares++;
                        $display("FAIL cmd_leds: leds=%h, required %h", leds, e.leds);
                    end
                    vectors++;
                    if (cyc < e.cyc0 + 9 * CPB || cyc > e.cyc0 + 10 * CPB) begin
                        miscompares++;
                        $display("FAIL cmd_latency: pulse %0d cycles after start bit, required within stop bit (%0d..%0d)",
                                 cyc - e.cyc0, 9 * CPB, 10 * CPB);
                    end
                    cur_leds = e.leds;
                end
            end else if (frame_err === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0 || !exp_q[0].is_ferr) begin
                    miscompares++;
                    $display("FAIL unexpected_frame_err: frame_err=1 at cycle %0d, required no pulse", cyc);
                end else begin
                    e = exp_q.pop_front();
                    vectors++;
                    if (leds !== cur_leds) begin
                        miscompares++;
                        $display("FAIL ferr_leds: leds=%h, required %h", leds, cur_leds);
                    end
                    vectors++;
                    if (cyc < e.cyc0 + 9 * CPB || cyc > e.cyc0 + 10 * CPB) begin
                        miscompares++;
                        $display("FAIL ferr_latency: pulse %0d cycles after start bit, required %0d..%0d",
                                 cyc - e.cyc0, 9 * CPB, 10 * CPB);
                    end
                end
            end else begin
                vectors++;
                if (leds !== cur_leds) begin
                    miscompares++;
                    $display("FAIL leds_stable: leds=%h without a pulse, required %h", leds, cur_leds);
                    cur_leds = leds;
                end
            end
        end
        prev_cv = (cmd_valid === 1'b1);
        prev_fe = (frame_err === 1'b1);
    end

    // Tasks start and end #1 after a posedge so frames can run back-to-back
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input bit expect_out, input logic [7:0] exp_leds);
        exp_t e;
        if (expect_out) begin
            e.is_ferr = !stop_ok;
            e.leds    = exp_leds;
            e.cyc0    = cyc;
            exp_q.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        idle(5);
        rst_n = 1'b1;
        idle(100);
        vectors++;
        if (leds !== 8'h01 || cmd_valid !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: leds=%h cmd_valid=%b frame_err=%b, required 01/0/0", leds, cmd_valid, frame_err);
        end
    endtask

    task automatic test_load();
        send_frame(8'h4C, 1'b1, 1'b0, 8'h00);
        send_frame(8'hA5, 1'b1, 1'b1, 8'hA5);
        idle(5);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL load_pending: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        vectors++;
        if (leds !== 8'hA5) begin
            miscompares++;
            $display("FAIL load_leds: leds=%h, required a5", leds);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h54, 1'b1, 1'b0, 8'h00);
        send_frame(8'hFF, 1'b1, 1'b1, 8'h5A);
        send_frame(8'h52, 1'b1, 1'b1, 8'hB4);
        send_frame(8'h43, 1'b1, 1'b1, 8'h00);
        idle(5);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_pending: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        vectors++;
        if (leds !== 8'h00) begin
            miscompares++;
            $display("FAIL b2b_leds: leds=%h, required 00", leds);
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h4C, 1'b1, 1'b0, 8'h00);
        send_frame(8'h3C, 1'b1, 1'b1, 8'h3C);
        send_frame(8'h4C, 1'b1, 1'b0, 8'h00);
        send_frame(8'h77, 1'b0, 1'b1, 8'h3C);
        rx = 1'b1;
        idle(20);
        send_frame(8'h33, 1'b1, 1'b0, 8'h00);
        send_frame(8'h52, 1'b1, 1'b1, 8'h78);
        idle(5);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL ferr_pending: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        vectors++;
        if (leds !== 8'h78) begin
            miscompares++;
            $display("FAIL ferr_after_leds: leds=%h, required 78", leds);
        end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(30);
        vectors++;
        if (leds !== 8'h78 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL glitch: leds=%h pending=%0d, required leds=78 pending=0", leds, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_arg_is_data();
        send_frame(8'h4C, 1'b1, 1'b0, 8'h00);
        send_frame(8'h4C, 1'b1, 1'b1, 8'h4C);
        send_frame(8'h52, 1'b1, 1'b1, 8'h98);
        idle(5);
        vectors++;
        if (leds !== 8'h98 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL arg_is_data: leds=%h pending=%0d, required leds=98 pending=0", leds, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_timeout();
        send_frame(8'h4C, 1'b1, 1'b0, 8'h00);
        idle(TIMEOUT + 20);
        send_frame(8'h11, 1'b1, 1'b0, 8'h00);
        send_frame(8'h52, 1'b1, 1'b1, 8'h31);
        idle(5);
        vectors++;
        if (leds !== 8'h31 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout: leds=%h pending=%0d, required leds=31 pending=0", leds, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h4C, 1'b1, 1'b0, 8'h00);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        #2;
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        vectors++;
        if (leds !== 8'h01) begin
            miscompares++;
            $display("FAIL async_reset: leds=%h right after rst_n fall, required 01", leds);
        end
        idle(5);
        rst_n = 1'b1;
        idle(10);
        send_frame(8'h4C, 1'b1, 1'b0, 8'h00);
        send_frame(8'h0F, 1'b1, 1'b1, 8'h0F);
        idle(5);
        vectors++;
        if (leds !== 8'h0F || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset_load: leds=%h pending=%0d, required leds=0f pending=0", leds, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_arg_is_data();
        test_timeout();
        test_reset_midframe();
        idle(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
